// File: rtl/dvi_pkg.sv
// Constants and types shared by the pixel feeder and the DVI output stage.
package dvi_pkg;

  localparam int PIX_W  = 32;
  localparam int WORD_W = 64;

  typedef logic [PIX_W-1:0]  dvi_pix_t;
  typedef logic [WORD_W-1:0] dvi_word_t;

  // The earlier pixel of a pair occupies the low half of the word.
  function automatic dvi_word_t pack_pair(input dvi_pix_t first, input dvi_pix_t second);
    return {second, first};
  endfunction

endpackage

// File: rtl/dvi_pixel_feeder_if.sv
// Renderer/DVI-facing signal bundle of the pixel feeder.
interface dvi_pixel_feeder_if #(
  parameter int DEPTH = 16
);
  import dvi_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             frame_start;
  logic             pix_valid;
  dvi_pix_t         pix_data;
  logic             request;
  dvi_word_t        data;
  logic             fill_req;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             underflow;

  modport master (
    output frame_start, pix_valid, pix_data, request,
    input  data, fill_req, level, overflow, underflow
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, request,
    output data, fill_req, level, overflow, underflow
  );

endinterface

// File: rtl/dvi_fifo_mem.sv
// DEPTH x 64 simple dual-port RAM: synchronous write, registered read with enable.
module dvi_fifo_mem
  import dvi_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  dvi_word_t     i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output dvi_word_t     o_rd_data
);

  dvi_word_t r_mem [DEPTH];
  dvi_word_t r_rd_data;

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // A read of the address being written returns the old contents (read-before-write).
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dvi_pixel_feeder.sv
// Packs renderer pixel pairs into 64-bit words, buffers them and pops one per DVI request.
module dvi_pixel_feeder
  import dvi_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input logic               clock,
  input logic               reset,
  dvi_pixel_feeder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          r_half;
  dvi_pix_t      r_low_hold;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_pair;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  dvi_word_t     w_word;
  dvi_word_t     w_rd_data;

  // frame_start suppresses both sides: a pixel that cycle starts a new pair, a request is ignored.
  assign w_pair  = bus.pix_valid && r_half && !bus.frame_start;
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = bus.request && !w_empty && !bus.frame_start;
  assign w_push  = w_pair && (!w_full || w_pop);
  assign w_word  = pack_pair(r_low_hold, bus.pix_data);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_half     <= 1'b0;
      r_low_hold <= '0;
    end else if (bus.frame_start) begin
      r_half <= bus.pix_valid;
      if (bus.pix_valid) r_low_hold <= bus.pix_data;
    end else if (bus.pix_valid) begin
      r_half <= !r_half;
      if (!r_half) r_low_hold <= bus.pix_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.frame_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.frame_start) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pair && w_full && !w_pop) r_overflow  <= 1'b1;
      if (bus.request && w_empty)     r_underflow <= 1'b1;
    end
  end

  dvi_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_word),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign bus.data      = w_rd_data;
  assign bus.level     = r_level;
  assign bus.fill_req  = (r_level <= LW'(LOW_WATER));
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_dvi_pixel_feeder.sv
// Scoreboard bench for dvi_pixel_feeder: a queue model predicts every popped word and flag.
module tb_dvi_pixel_feeder;
  import dvi_pkg::*;

  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  dvi_pixel_feeder_if #(.DEPTH(DEPTH)) bus ();

  dvi_pixel_feeder #(
    .DEPTH     (DEPTH),
    .LOW_WATER (LOW_WATER)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  dvi_word_t exp_q[$];
  bit        m_half;
  dvi_pix_t  m_low;
  bit        m_ovf;
  bit        m_unf;
  dvi_word_t m_data;
  dvi_pix_t  pix_cnt = 32'h1000_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, 64'(bus.level), 64'(exp_q.size()));
    check({tag, "_fill"}, 64'(bus.fill_req), 64'(exp_q.size() <= LOW_WATER));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(m_ovf));
    check({tag, "_unf"}, 64'(bus.underflow), 64'(m_unf));
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.request     = 1'b0;
    exp_q.delete();
    m_half = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_data = '0;
    #1;
    check("rst_data", bus.data, 64'h0);
    check_status("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock: drive at negedge, update the model at posedge, compare 1 time unit later.
  task automatic cycle(input bit fs, input bit pv, input dvi_pix_t pd, input bit rq);
    int sz0;
    bit popped;
    @(negedge clock);
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_data    = pd;
    bus.request     = rq;
    @(posedge clock);
    sz0    = exp_q.size();
    popped = 1'b0;
    if (fs) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_half = pv;
      if (pv) m_low = pd;
    end else begin
      if (rq && sz0 == 0) m_unf = 1'b1;
      if (rq && sz0 > 0) begin
        m_data = exp_q.pop_front();
        popped = 1'b1;
      end
      if (pv) begin
        if (!m_half) begin
          m_low  = pd;
          m_half = 1'b1;
        end else begin
          m_half = 1'b0;
          if (sz0 < DEPTH || popped) exp_q.push_back({pd, m_low});
          else                       m_ovf = 1'b1;
        end
      end
    end
    #1;
    if (rq && !fs) check(popped ? "pop_data" : "hold_data", bus.data, m_data);
    check_status("cyc");
  endtask

  task automatic pixel(input bit rq);
    cycle(1'b0, 1'b1, pix_cnt, rq);
    pix_cnt = pix_cnt + 32'd1;
  endtask

  task automatic idle_pop();
    cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    apply_reset();

    // Basic pair then pop
    cycle(1'b0, 1'b1, 32'h1111_1111, 1'b0);
    cycle(1'b0, 1'b1, 32'h2222_2222, 1'b0);
    idle_pop();
    check("t1_data", bus.data, 64'h2222_2222_1111_1111);
    check("t1_level", 64'(bus.level), 64'd0);
    check("t1_unf", 64'(bus.underflow), 64'd0);

    // Overfill: one word dropped, then drain in order
    for (int i = 0; i < 2 * DEPTH + 2; i++) pixel(1'b0);
    check("t2_level", 64'(bus.level), 64'(DEPTH));
    check("t2_ovf", 64'(bus.overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) idle_pop();
    check("t2_empty", 64'(bus.level), 64'd0);

    // Reset in the middle of a pair discards the half pixel
    pixel(1'b0);
    apply_reset();
    pixel(1'b0);
    pixel(1'b0);
    idle_pop();

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 2 * DEPTH; i++) pixel(1'b0);
    check("t3_full", 64'(bus.level), 64'(DEPTH));
    pixel(1'b0);
    pixel(1'b1);
    check("t3_level", 64'(bus.level), 64'(DEPTH));
    check("t3_ovf", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < DEPTH; i++) idle_pop();

    // Underflow holds the last word; frame_start clears the flag
    cycle(1'b0, 1'b1, 32'hA000_0001, 1'b0);
    cycle(1'b0, 1'b1, 32'hA000_0002, 1'b0);
    idle_pop();
    idle_pop();
    check("t4_hold", bus.data, 64'hA000_0002_A000_0001);
    check("t4_unf", 64'(bus.underflow), 64'd1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check("t4_clear", 64'(bus.underflow), 64'd0);

    // Odd pixel count, flushed by a frame_start that carries a pixel and a request
    for (int i = 0; i < 3; i++) pixel(1'b0);
    cycle(1'b1, 1'b1, 32'h0000_00BB, 1'b1);
    check("t5_flush", 64'(bus.level), 64'd0);
    cycle(1'b0, 1'b1, 32'h0000_00CC, 1'b0);
    idle_pop();
    check("t5_data", bus.data, 64'h0000_00CC_0000_00BB);

    // Wrap-around with level oscillating across LOW_WATER
    for (int i = 0; i < 2 * (LOW_WATER + 1); i++) pixel(1'b0);
    for (int i = 0; i < 6 * DEPTH; i++) pixel((i % 8) < 4);
    while (exp_q.size() > 0) idle_pop();
    check("t6_empty", 64'(bus.level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_pixel_feeder.md
# dvi_pixel_feeder

Upstream feeder for the DVI output stage. Accepts one 32-bit pixel per clock from the frame renderer, packs pixel pairs into 64-bit words and buffers them in a small FIFO. Each `request` pulse from the DVI stage pops one word onto the registered `data` bus. Also drives a low-water fetch hint to the renderer and raises sticky overflow/underflow flags for debug.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in 64-bit words; power of two, at least 4.
- `LOW_WATER`, 4: `fill_req` is asserted while the FIFO level is at or below this value.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse at the start of each frame; synchronous flush.
- `pix_valid`  in  1  `pix_data` is valid this cycle.
- `pix_data`  in  32  one pixel.
- `request`  in  1  pop one word; sampled on the rising edge.
- `data`  out  64  registered output word consumed by the DVI stage.
- `fill_req`  out  1  FIFO level is at or below `LOW_WATER`.
- `level`  out  $clog2(DEPTH)+1  number of words currently stored.
- `overflow`  out  1  sticky: a packed word was dropped because the FIFO was full.
- `underflow`  out  1  sticky: `request` arrived while the FIFO was empty.

## Operation
- Packer: a 1-bit `half` flag and a 32-bit `low_hold` register.
  - `pix_valid` with `half`=0: store the pixel in `low_hold`, set `half`=1.
  - `pix_valid` with `half`=1: form the word {`pix_data`, `low_hold`}, so the first pixel lands in [31:0] and the second in [63:32]. Assert a push for that cycle and clear `half`.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate `level` counter from 0 to DEPTH.
  - Push when level<DEPTH: write the word and increment the write pointer.
  - Push when full with a simultaneous pop: accepted, and `level` is unchanged.
  - Push when full without a pop: word is dropped and `overflow` is set.
- Pop: on a `request` edge with level>0, `data` ← mem[rd_ptr], the read pointer increments and `level` decrements.
  - With level==0, `data` holds its previous value, `underflow` is set and the pointers are unchanged.
  - A push in the same cycle as a pop on an empty FIFO is not bypassed: the pop underflows and the push is stored.
- `frame_start` (synchronous, highest priority after reset):
  - Clears both pointers, `level`, `half`, `overflow` and `underflow`. `data` is unchanged.
  - A `request` in the same cycle is ignored.
  - A `pix_valid` in the same cycle is accepted as the first pixel of the new frame (`low_hold` ← `pix_data`, `half` ← 1).
- `fill_req` is combinational from `level`: `level` <= `LOW_WATER`.

## Timing
- Reset values: `data`=0, `level`=0, `fill_req`=1, `overflow`=0, `underflow`=0, `half`=0, both pointers 0. Reset can arrive at any time, including mid-pair; a half-packed pixel is discarded.
- Pixel-to-pop latency: a pair completed at edge N is written at edge N. It is poppable by the `request` edge at N+1 and appears on `data` after that edge.
- Pop latency: `data` changes on the same rising edge that samples `request`, so it is stable for the DVI stage's next negedge/posedge use.
- `request` held high for k cycles pops k words; no handshake acknowledge is provided.
- Flags update on the edge of the causing event and stay set until `frame_start` or `reset`.

## Structure
- Shared package `dvi_pkg`: `PIX_W`=32, `WORD_W`=64, and the `dvi_word_t` typedef. The DVI stage uses the same constants.
- One sub-module, `dvi_fifo_mem`: a DEPTH×64 simple dual-port RAM with synchronous write and synchronous read-enable. It maps to block RAM.
- The packer, pointers, level counter and flags live in the top module.

## Test plan
- Reset, then push pixels 0x11111111 and 0x22222222 followed by one `request` → `data`=0x2222222211111111, `level` returns to 0, `underflow`=0.
- Push 2×DEPTH+2 pixels with no `request` → `level`=DEPTH, `overflow`=1, and the dropped word is never seen. Then DEPTH pops return words 0..DEPTH-1 in order.
- Reach full, then push and `request` in the same cycle → `level` stays DEPTH and `overflow` stays 0.
- `request` on an empty FIFO after a word 0xA… was last output → `data` holds 0xA…, `underflow`=1. A following `frame_start` clears `underflow`.
- Odd pixel count followed by `frame_start` carrying `pix_valid`=0xBB → the stale half is discarded. Next pixel 0xCC yields word 0x000000CC000000BB.
- Wrap-around: sustained pushes and pops over 3×DEPTH words with `level` oscillating around `LOW_WATER` → data order is preserved, and `fill_req` toggles exactly at `level`=LOW_WATER / LOW_WATER+1.
